vga_sync_decoder: RTL and testbench

- Receive-side counterpart of the VGA timing generator: takes h_sync/v_sync, rebuilds beam position x/y and frame_active, and reports lock state.
- Used as a bench checker for generator output and for loop-back/genlock tests.
- Same clock domain as the generator; no CDC.

---
 rtl/vga_sync_decoder.sv | 182 ++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Receive-side companion of the VGA timing generator. Recovers the beam
//   position from the h_sync/v_sync pins, flags sync edges that arrive at
//   the wrong position, and reports whether the recovered timing is locked.
//   Runs in the generator's clock domain.
//
// Ports
//   clk          in   pixel clock
//   rst          in   asynchronous reset, active-high
//   h_sync_in    in   horizontal sync, active-high
//   v_sync_in    in   vertical sync, active-high
//   x            out  [9:0] recovered column
//   y            out  [9:0] recovered row
//   frame_active out  locked and inside the visible area
//   locked       out  high while in LOCKED state
//   h_err        out  one-cycle pulse: h edge arrived with x != H_ALIGN
//   v_err        out  one-cycle pulse: v edge arrived with y != V_ALIGN, or timeout
module vga_sync_decoder #(
  parameter int unsigned W_DISPLAY   = 640,
  parameter int unsigned W_MAX       = 799,
  parameter int unsigned H_DISPLAY   = 480,
  parameter int unsigned H_MAX       = 524,
  parameter int unsigned H_ALIGN     = 658,
  parameter int unsigned V_ALIGN     = 490,
  parameter int unsigned LOCK_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_active,
  output logic       locked,
  output logic       h_err,
  output logic       v_err
);

  localparam logic [9:0]  W_DISP_C  = 10'(W_DISPLAY);
  localparam logic [9:0]  W_MAX_C   = 10'(W_MAX);
  localparam logic [9:0]  H_DISP_C  = 10'(H_DISPLAY);
  localparam logic [9:0]  H_MAX_C   = 10'(H_MAX);
  localparam logic [9:0]  H_ALIGN_C = 10'(H_ALIGN);
  localparam logic [9:0]  V_ALIGN_C = 10'(V_ALIGN);
  localparam logic [3:0]  LOCK_C    = 4'(LOCK_FRAMES);
  localparam bit          ALIGN_WRAPS = (H_ALIGN >= W_MAX);
  localparam logic [9:0]  X_LOAD    = ALIGN_WRAPS ? '0 : 10'(H_ALIGN + 1);
  localparam logic [10:0] H_TO      = 11'(2 * (W_MAX + 1));
  localparam logic [10:0] V_TO      = 11'(2 * (H_MAX + 1));

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  logic        h_q, h_prev_q, v_q, v_prev_q;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [10:0] h_gap_q, h_gap_d, v_gap_q, v_gap_d;
  state_t      state_q;
  logic [3:0]  good_q;
  logic        err_seen_q;
  logic        locked_q, h_err_q, v_err_q;

  logic h_edge, v_edge, line_end, h_mis, v_mis, h_to, v_to, timeout, frame_bad;

  always_comb begin
    h_edge = h_q & ~h_prev_q;
    v_edge = v_q & ~v_prev_q;

    // A realign load that lands on 0 still closes the line for the y counter.
    line_end = h_edge ? ALIGN_WRAPS : (x_q == W_MAX_C);

    x_d = (x_q == W_MAX_C) ? '0 : x_q + 10'd1;
    if (h_edge) x_d = X_LOAD;

    y_d = y_q;
    if (v_edge)        y_d = V_ALIGN_C;
    else if (line_end) y_d = (y_q == H_MAX_C) ? '0 : y_q + 10'd1;

    h_mis = h_edge && (x_q != H_ALIGN_C);
    v_mis = v_edge && (y_q != V_ALIGN_C);

    h_gap_d = (h_gap_q == '1) ? h_gap_q : h_gap_q + 11'd1;
    if (h_edge) h_gap_d = '0;

    v_gap_d = v_gap_q;
    if (v_edge)                         v_gap_d = '0;
    else if (line_end && v_gap_q != '1) v_gap_d = v_gap_q + 11'd1;

    // Fire only on the step that reaches the threshold; saturation keeps it from repeating.
    h_to    = !h_edge && (h_gap_q == H_TO - 11'd1);
    v_to    = !v_edge && line_end && (v_gap_q == V_TO - 11'd1);
    timeout = h_to | v_to;

    // Errors detected on the closing v_edge belong to the frame that is ending.
    frame_bad = err_seen_q | h_mis | v_mis;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q      <= 1'b0;
      h_prev_q <= 1'b0;
      v_q      <= 1'b0;
      v_prev_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      h_gap_q  <= '0;
      v_gap_q  <= '0;
    end else begin
      h_q      <= h_sync_in;
      h_prev_q <= h_q;
      v_q      <= v_sync_in;
      v_prev_q <= v_q;
      x_q      <= x_d;
      y_q      <= y_d;
      h_gap_q  <= h_gap_d;
      v_gap_q  <= v_gap_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SEARCH;
      good_q     <= '0;
      err_seen_q <= 1'b0;
      locked_q   <= 1'b0;
      h_err_q    <= 1'b0;
      v_err_q    <= 1'b0;
    end else begin
      h_err_q <= h_mis;
      v_err_q <= v_mis | timeout;

      if (v_edge)              err_seen_q <= 1'b0;
      else if (h_mis | v_mis)  err_seen_q <= 1'b1;

      if (timeout) begin
        state_q  <= SEARCH;
        good_q   <= '0;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          SEARCH: begin
            if (v_edge) begin
              state_q <= TRACK;
              good_q  <= '0;
            end
          end
          TRACK: begin
            if (v_edge) begin
              if (frame_bad) begin
                good_q <= '0;
              end else begin
                good_q <= good_q + 4'd1;
                if (good_q + 4'd1 == LOCK_C) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                end
              end
            end
          end
          LOCKED: begin
            if (h_mis | v_mis) begin
              state_q  <= TRACK;
              good_q   <= '0;
              locked_q <= 1'b0;
            end
          end
          default: begin
            state_q  <= SEARCH;
            good_q   <= '0;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign locked       = locked_q;
  assign h_err        = h_err_q;
  assign v_err        = v_err_q;
  assign frame_active = locked_q && (x_q < W_DISP_C) && (y_q < H_DISP_C);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down raster (20x10 total, 8x6
// visible) so every scenario fits in a few thousand cycles. A behavioural
// generator drives registered syncs: h_sync high for x=12..15 one cycle
// late (edge seen at x=14), v_sync high for y=7..8 (edge seen at y=7, x=2).
module tb_vga_sync_decoder;
  localparam int WD = 8, WM = 19, HD = 6, HM = 9, HA = 14, VA = 7, LF = 3;

  logic       clk = 1'b0;
  logic       rst, h_sync_in, v_sync_in;
  logic [9:0] x, y;
  logic       frame_active, locked, h_err, v_err;

  int n_checks = 0;
  int n_fail   = 0;

  int   gx, gy, line_len, hdel_line, ve_cnt, sx, herr_cnt, verr_cnt;
  bit   sync_en, hs_force, chk_lock, lock_seen;
  logic hs_pend, vs_pend;

  vga_sync_decoder #(
    .W_DISPLAY(WD), .W_MAX(WM), .H_DISPLAY(HD), .H_MAX(HM),
    .H_ALIGN(HA), .V_ALIGN(VA), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst(rst), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .x(x), .y(y), .frame_active(frame_active), .locked(locked),
    .h_err(h_err), .v_err(v_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Generator: inputs for this cycle come from the previous cycle's position.
  task automatic drive();
    int lo, hi;
    h_sync_in = hs_pend;
    v_sync_in = vs_pend;
    lo = 12 + ((gy == hdel_line) ? 3 : 0);
    hi = lo + 3;
    hs_pend = hs_force || (sync_en && gx >= lo && gx <= hi);
    vs_pend = sync_en && gy >= VA && gy <= VA + 1;
    gx++;
    if (gx == line_len) begin
      gx = 0;
      gy = (gy == HM) ? 0 : gy + 1;
    end
  endtask

  // Lock expected from the cycle after the (LF+1)-th v edge since the last disturbance.
  task automatic step();
    @(negedge clk);
    if (chk_lock) begin
      check_eq("locked", locked, ve_cnt >= LF + 1);
      if (ve_cnt >= LF + 1) begin
        check_eq("x", x, gx);
        check_eq("y", y, gy);
        check_eq("frame_active", frame_active, (gx < WD) && (gy < HD));
        check_eq("h_err", h_err, 0);
        check_eq("v_err", v_err, 0);
      end
    end
    if (sync_en && gy == VA && gx == 2) ve_cnt++;
    drive();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; h_sync_in = 1'b0; v_sync_in = 1'b0;
    hs_pend = 1'b0; vs_pend = 1'b0;
    sync_en = 1'b1; hs_force = 1'b0; chk_lock = 1'b0; lock_seen = 1'b0;
    line_len = WM + 1; hdel_line = -1; gx = 0; gy = 0; ve_cnt = 0;

    repeat (3) @(negedge clk);
    check_eq("rst_x", x, 0);
    check_eq("rst_y", y, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_h_err", h_err, 0);
    check_eq("rst_v_err", v_err, 0);
    check_eq("rst_frame_active", frame_active, 0);
    rst = 1'b0;
    drive();
    chk_lock = 1'b1;

    // Initial acquisition, then several clean locked frames.
    repeat (1800) step();

    // One h pulse late by 3 cycles on line 2.
    while (!(gy == 0 && gx == 0)) step();
    hdel_line = 2;
    while (!(gy == 2 && gx == HA + 3)) step();
    step();
    check_eq("x_late_edge", x, HA + 3);
    ve_cnt = 0;
    step();
    check_eq("h_err_late", h_err, 1);
    check_eq("x_reload", x, HA + 1);
    check_eq("locked_drop", locked, 0);
    while (!(gy == 3 && gx == HA + 1)) step();
    hdel_line = -1;
    step();
    check_eq("h_err_realign", h_err, 1);
    check_eq("x_realign", x, HA + 1);
    repeat (1800) step();

    // Both syncs stopped: last h edge 6 cycles before k=0, timeout 41 cycles after it.
    while (!(gy == 0 && gx == 0)) step();
    sync_en = 1'b0;
    chk_lock = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      check_eq("v_err_stop", v_err, k == 35);
      check_eq("h_err_stop", h_err, 0);
      check_eq("locked_stop", locked, k < 35);
    end
    sync_en = 1'b1;
    ve_cnt = 0;
    chk_lock = 1'b1;
    repeat (1800) step();

    // Reset pulse mid-frame.
    while (!(gy == 3 && gx == 5)) step();
    #1 rst = 1'b1;
    #1;
    check_eq("midrst_x", x, 0);
    check_eq("midrst_y", y, 0);
    check_eq("midrst_locked", locked, 0);
    @(negedge clk);
    rst = 1'b0;
    ve_cnt = 0;
    drive();
    repeat (1800) step();

    // h_sync held high from inside a pulse: last edge at k=1, timeout at k=42.
    while (!(gy == 0 && gx == 13)) step();
    hs_force = 1'b1;
    chk_lock = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      check_eq("v_err_hold", v_err, k == 42);
      check_eq("h_err_hold", h_err, 0);
      check_eq("locked_hold", locked, k < 42);
    end
    hs_force = 1'b0;
    ve_cnt = 0;
    chk_lock = 1'b1;
    repeat (1800) step();

    // 21-cycle lines: decoder runs one ahead each line from line 1 on.
    while (!(gy == 0 && gx == 0)) step();
    line_len = WM + 2;
    chk_lock = 1'b0;
    herr_cnt = 0;
    verr_cnt = 0;
    for (int ln = 0; ln < 30; ln++) begin
      for (int c = 0; c < WM + 2; c++) begin
        sx = gx;
        step();
        if (h_err === 1'b1) herr_cnt++;
        if (v_err === 1'b1) verr_cnt++;
        if (ln >= 2 && locked !== 1'b0) lock_seen = 1'b1;
        if (ln >= 1 && sx == HA + 1) begin
          check_eq("h_err_long_line", h_err, 1);
          check_eq("x_long_line", x, HA + 1);
        end
      end
    end
    check_eq("h_err_count_long", herr_cnt, 29);
    check_eq("v_err_count_long", verr_cnt, 0);
    check_eq("locked_long", lock_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
